zbt_accumulator: RTL and testbench
==================================

# zbt_accumulator

Parametrised read-modify-write accumulator between the pixel pipeline and the ZBT SRAM port. It packs `LANES` pixels per memory word and updates only the addressed lane, preserving the others. Each accepted pixel is folded into the stored value using a per-transaction mode: overwrite, max, min, or saturating add. Writes to the same word in flight are forwarded, so back-to-back updates to one word are exact, and a built-in sweep clears the frame.

## Interface

- `PIX_W`, 8, pixel width
- `LANES`, 4, pixels per memory word (power of 2)
- `X_W`, 10, x coordinate width
- `Y_W`, 10, y coordinate width
- `DATA_W`, 36, memory word width (≥ `LANES*PIX_W`; pad bits written 0)
- `RD_LAT`, 2, cycles from `rd_en` to `rd_data` valid
- `CLEAR_LAST`, 2^ADDR_W−1, last word address touched by a clear sweep
- `CLEAR_VAL`, 0, pixel value written by clear
- derived: `LB = log2(LANES)`, `ADDR_W = Y_W + X_W − LB`
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: pixel update offered
- `in_ready` out 1: update accepted when both `in_valid` and `in_ready` are high
- `x` in X_W, `y` in Y_W, `pixel` in PIX_W, `mode` in 2: update payload
- `clear_start` in 1: request a clear sweep (level-sampled)
- `clear_busy` out 1: sweep pending or running
- `rd_en` out 1, `rd_addr` out ADDR_W: memory read request
- `rd_data` in DATA_W: read data, valid `RD_LAT` cycles after `rd_en`
- `wr_en` out 1, `wr_addr` out ADDR_W, `wr_data` out DATA_W: memory write

## Operation

- Word address is `{y, x[X_W-1:LB]}`. The lane is `x[LB-1:0]`. Lane k occupies bits `[k*PIX_W +: PIX_W]`.
- Mode is carried with each transaction:
  - 0 = overwrite: `new = pixel`
  - 1 = max
  - 2 = min
  - 3 = saturating add: `new = min(old + pixel, 2^PIX_W − 1)`, computed at PIX_W+1 bits
- Memory model: a write in cycle w is visible only to reads issued in cycles after w.
- Required result: final memory contents equal strictly sequential application of all accepted updates in acceptance order, for any spacing, including every cycle to the same word.
  - Implement with a forwarding window over the last `RD_LAT+1` issued writes. On multiple matches, the newest write wins.
- Non-addressed lanes are written back unchanged, taken from the forwarded or read word. Pad bits are written as 0.
- Clear sweep:
  - `clear_start` sampled high makes `clear_busy` go high on the next edge and drops `in_ready`.
  - Issue no reads. Wait until no transaction is in flight.
  - Write `CLEAR_VAL` replicated into all lanes to addresses 0..`CLEAR_LAST`, one per cycle, ascending.
  - Release `clear_busy` and raise `in_ready` the cycle after the last write.
- Simultaneous `clear_start` and an accepted update: the update completes first, then the sweep overwrites it.
- `clear_start` while `clear_busy` is high is ignored.

## Timing

- Reset values: `in_ready`=1; `clear_busy`, `rd_en`, `wr_en`=0; all addresses and data=0.
- Accept at edge t:
  - `rd_en`/`rd_addr` are registered and high during cycle t+1.
  - `rd_data` is sampled at t+1+`RD_LAT`.
  - `wr_en`/`wr_addr`/`wr_data` are registered and high during cycle t+2+`RD_LAT`.
- Sustained throughput is one update per cycle. `in_ready` never drops except for a clear.
- Reset mid-operation: in-flight transactions and any sweep are discarded. No `wr_en` is asserted from reset assertion until new accepts occur after release.

## Structure

- Package `zbt_acc_pkg`: mode constants (`MODE_WR`, `MODE_MAX`, `MODE_MIN`, `MODE_ADD`) and the address/lane split function.
- Sub-module `zbt_lane_alu`: combinational. Takes old pixel, new pixel and mode; returns the result. Instantiated once, on the addressed lane only.
- Top module: input pipeline of depth `RD_LAT+1`, forwarding window, lane merge, clear FSM (states IDLE → DRAIN → SWEEP → IDLE).

## Test plan

- Reset: hold `rst_n`=0 → `in_ready`=1, all other outputs 0, no `wr_en` for 10 cycles after release.
- Max, lane insert:
  - Stimulus: memory word 773 (y=3, x=22) = 0x0_10_20_30_40; pixel 0x25, mode 1.
  - Response: one write to address 773 of 0x0_10_25_30_40, at accept+4 cycles with `RD_LAT`=2.
- Back-to-back hazard:
  - Stimulus: word 0x0_00_00_00_20; four consecutive add-mode updates of 0xF0 to lane 0.
  - Response: final lane 0 = 0xFF; intermediate writes 0x10 is never produced, the sequence is 0xFF ×4.
- Mixed lanes, same word, every cycle:
  - Stimulus: overwrite lanes 0..3 with 0x11,0x22,0x33,0x44, then min with 0x30 on lane 3.
  - Response: final word 0x0_30_33_22_11.
- Clear (`CLEAR_LAST`=15, `CLEAR_VAL`=0x80): assert `clear_start` with one update in flight.
  - Response: the update writes first, then 16 writes to addresses 0..15 with data 0x0_80_80_80_80.
  - `in_ready` stays low throughout and `rd_en` stays 0.
- Reset mid-pipeline: drop `rst_n` one cycle after an accept → no `wr_en` ever appears for that transaction.

Source files
------------

// File: rtl/zbt_acc_pkg.sv
// zbt_acc_pkg: mode codes and address/lane split helpers
// shared by the ZBT read-modify-write accumulator.
package zbt_acc_pkg;

  localparam logic [1:0] MODE_WR  = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;
  localparam logic [1:0] MODE_ADD = 2'd3;

  function automatic logic [31:0] word_addr(
    input logic [31:0] y,
    input logic [31:0] x,
    input int          xw,
    input int          lb
  );
    return (y << (xw - lb)) | (x >> lb);
  endfunction

  function automatic logic [31:0] lane_of(
    input logic [31:0] x,
    input int          lb
  );
    return x & ((32'd1 << lb) - 32'd1);
  endfunction

endpackage

// File: rtl/zbt_lane_alu.sv
// zbt_lane_alu: folds one incoming pixel into the stored
// pixel of the addressed lane (overwrite/max/min/sat-add).
module zbt_lane_alu #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] old_pix,
  input  logic [PIX_W-1:0] new_pix,
  input  logic [1:0]       mode,
  output logic [PIX_W-1:0] res
);
  import zbt_acc_pkg::*;

  logic [PIX_W:0] sum;

  assign sum = {1'b0, old_pix} + {1'b0, new_pix};

  always_comb begin
    res = new_pix;
    unique case (1'b1)
      (mode == MODE_WR):
        res = new_pix;
      (mode == MODE_MAX):
        res = (new_pix > old_pix) ? new_pix : old_pix;
      (mode == MODE_MIN):
        res = (new_pix < old_pix) ? new_pix : old_pix;
      (mode == MODE_ADD):
        res = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
      default:
        res = new_pix;
    endcase
  end

endmodule

// File: rtl/zbt_accumulator.sv
// zbt_accumulator: pipelined read-modify-write of packed pixel
// lanes in ZBT SRAM, with write forwarding and a clear sweep.
module zbt_accumulator #(
  parameter int          PIX_W      = 8,
  parameter int          LANES      = 4,
  parameter int          X_W        = 10,
  parameter int          Y_W        = 10,
  parameter int          DATA_W     = 36,
  parameter int          RD_LAT     = 2,
  parameter int unsigned CLEAR_LAST =
    (32'd1 << (Y_W + X_W - $clog2(LANES))) - 32'd1,
  parameter logic [PIX_W-1:0] CLEAR_VAL = '0,
  localparam int LB     = $clog2(LANES),
  localparam int ADDR_W = Y_W + X_W - LB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [PIX_W-1:0]  pixel,
  input  logic [1:0]        mode,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  import zbt_acc_pkg::*;

  localparam int PW = LANES * PIX_W;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_C = CW'(CLEAR_LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_SWEEP
  } clr_st_t;

  clr_st_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sweep_wr;

  logic              accept;
  logic [31:0]       a32;
  logic [31:0]       l32;
  logic [ADDR_W-1:0] acc_addr;
  logic [LB-1:0]     acc_lane;
  logic              unused_bits;

  logic [RD_LAT:0]   p_v;
  logic [ADDR_W-1:0] p_a  [RD_LAT+1];
  logic [LB-1:0]     p_l  [RD_LAT+1];
  logic [PIX_W-1:0]  p_px [RD_LAT+1];
  logic [1:0]        p_m  [RD_LAT+1];

  logic [RD_LAT-1:0] h_v;
  logic [ADDR_W-1:0] h_a [RD_LAT];
  logic [PW-1:0]     h_d [RD_LAT];

  logic [PW-1:0]     wr_word;
  logic [PW-1:0]     base;
  logic [PW-1:0]     merged;
  logic [PIX_W-1:0]  old_pix;
  logic [PIX_W-1:0]  new_pix;

  assign a32      = word_addr(32'(y), 32'(x), X_W, LB);
  assign l32      = lane_of(32'(x), LB);
  assign acc_addr = a32[ADDR_W-1:0];
  assign acc_lane = l32[LB-1:0];
  assign unused_bits = ^{a32, l32, rd_data};

  assign in_ready   = (state_q == S_IDLE);
  assign clear_busy = (state_q != S_IDLE);
  assign accept     = in_valid & in_ready;

  assign rd_en   = p_v[0];
  assign rd_addr = p_a[0];
  assign wr_data = DATA_W'(wr_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        p_a[i]  <= '0;
        p_l[i]  <= '0;
        p_px[i] <= '0;
        p_m[i]  <= '0;
      end
    end else begin
      p_v[0] <= accept;
      if (accept) begin
        p_a[0]  <= acc_addr;
        p_l[0]  <= acc_lane;
        p_px[0] <= pixel;
        p_m[0]  <= mode;
      end
      for (int i = 1; i <= RD_LAT; i++) begin
        p_v[i]  <= p_v[i-1];
        p_a[i]  <= p_a[i-1];
        p_l[i]  <= p_l[i-1];
        p_px[i] <= p_px[i-1];
        p_m[i]  <= p_m[i-1];
      end
    end
  end

  // Writes still invisible to the read being merged now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        h_a[i] <= '0;
        h_d[i] <= '0;
      end
    end else begin
      h_v[0] <= wr_en;
      h_a[0] <= wr_addr;
      h_d[0] <= wr_word;
      for (int i = 1; i < RD_LAT; i++) begin
        h_v[i] <= h_v[i-1];
        h_a[i] <= h_a[i-1];
        h_d[i] <= h_d[i-1];
      end
    end
  end

  always_comb begin
    base = rd_data[PW-1:0];
    for (int i = RD_LAT - 1; i >= 0; i--) begin
      if (h_v[i] && h_a[i] == p_a[RD_LAT])
        base = h_d[i];
    end
    if (wr_en && wr_addr == p_a[RD_LAT])
      base = wr_word;
  end

  assign old_pix = base[p_l[RD_LAT]*PIX_W +: PIX_W];

  zbt_lane_alu #(
    .PIX_W(PIX_W)
  ) u_alu (
    .old_pix(old_pix),
    .new_pix(p_px[RD_LAT]),
    .mode   (p_m[RD_LAT]),
    .res    (new_pix)
  );

  always_comb begin
    merged = base;
    merged[p_l[RD_LAT]*PIX_W +: PIX_W] = new_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_word <= '0;
    end else if (sweep_wr) begin
      wr_en   <= 1'b1;
      wr_addr <= cnt_q[ADDR_W-1:0];
      wr_word <= {LANES{CLEAR_VAL}};
    end else begin
      wr_en <= p_v[RD_LAT];
      if (p_v[RD_LAT]) begin
        wr_addr <= p_a[RD_LAT];
        wr_word <= merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep ends one idle cycle after its last write
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_wr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear_start)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (p_v == '0) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        if (cnt_q > LAST_C) begin
          state_d = S_IDLE;
        end else begin
          sweep_wr = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_zbt_accumulator.sv
// tb_zbt_accumulator: directed and random checks of the
// accumulator against a sequential lane-update model.
module tb_zbt_accumulator;

  typedef struct {
    int          addr;
    logic [35:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [7:0]  pixel = '0;
  logic [1:0]  mode = '0;
  logic        clear_start = 1'b0;
  logic        clear_busy;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [35:0] rd_data;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [35:0] wr_data;

  logic [35:0] mem   [0:262143] = '{default: '0};
  logic [35:0] ref_m [0:262143] = '{default: '0};
  logic [35:0] dl [2];
  logic        poke_en = 1'b0;
  logic [17:0] poke_a = '0;
  logic [35:0] poke_d = '0;

  exp_t expq [$];
  int   wcyc [$];
  int   cyc = 0;
  int   nwr = 0;
  int   checks = 0;
  int   fails = 0;

  zbt_accumulator #(
    .CLEAR_LAST(15),
    .CLEAR_VAL (8'h80)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .pixel      (pixel),
    .mode       (mode),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: reads see only writes from earlier cycles
  always @(posedge clk) begin
    dl[0] <= rd_en ? mem[rd_addr] : 36'h5A5A5A5A5;
    dl[1] <= dl[0];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (poke_en) mem[poke_a] <= poke_d;
  end

  assign rd_data = dl[1];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] apply(input logic [35:0] w,
      input int ln, input int px, input int md);
    int lv [4];
    logic [35:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) lv[k] = int'((w >> (8 * k)) & 36'hFF);
    case (md)
      0: lv[ln] = px;
      1: lv[ln] = (px > lv[ln]) ? px : lv[ln];
      2: lv[ln] = (px < lv[ln]) ? px : lv[ln];
      default: lv[ln] = (lv[ln] + px > 255) ? 255 : lv[ln] + px;
    endcase
    for (int k = 0; k < 4; k++) r = r | (36'(lv[k]) << (8 * k));
    return r;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (wr_en) begin
      nwr++;
      wcyc.push_back(cyc);
      chk("wr_expected", 64'(expq.size() > 0), 64'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
        if (e.due >= 0) chk("wr_time", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic poke(input int a, input logic [35:0] d);
    poke_a = 18'(a);
    poke_d = d;
    poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    ref_m[a] = d;
  endtask

  task automatic send(input int xx, input int yy, input int px,
                      input int md);
    int   g;
    int   a;
    exp_t e;
    g = 0;
    x = 10'(xx);
    y = 10'(yy);
    pixel = 8'(px);
    mode = 2'(md);
    in_valid = 1'b1;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    if (in_ready) begin
      a = yy * 256 + xx / 4;
      ref_m[a] = apply(ref_m[a], xx % 4, px, md);
      e.addr = a;
      e.data = ref_m[a];
      e.due = cyc + 4;
      expq.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expq.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 64'(expq.size()), 64'd0);
    expq.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   n0;
    int   g;
    exp_t e;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(clear_busy), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    n0 = nwr;
    repeat (10) @(negedge clk);
    chk("rst_quiet", 64'(nwr), 64'(n0));

    poke(773, 36'h010203040);
    send(22, 3, 8'h25, 1);
    drain();
    chk("max_word", 64'(mem[773]), 64'h010253040);

    poke(256, 36'h000000020);
    for (int i = 0; i < 4; i++) send(0, 1, 8'hF0, 3);
    drain();
    chk("hazard_word", 64'(mem[256]), 64'h0000000FF);

    send(8, 2, 8'h11, 0);
    send(9, 2, 8'h22, 0);
    send(10, 2, 8'h33, 0);
    send(11, 2, 8'h44, 0);
    send(11, 2, 8'h30, 2);
    drain();
    chk("mixed_word", 64'(mem[514]), 64'h030332211);

    for (int w = 0; w < 4; w++)
      poke(1792 + w, 36'({$urandom(), $urandom()}));
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      send($urandom_range(0, 15), 7, $urandom_range(0, 255),
           $urandom_range(0, 3));
    end
    drain();
    for (int w = 0; w < 4; w++)
      chk("rand_word", 64'(mem[1792 + w]), 64'(ref_m[1792 + w]));

    n0 = nwr;
    x = 10'd4;
    y = 10'd9;
    pixel = 8'h99;
    mode = 2'd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_wr", 64'(nwr), 64'(n0));
    chk("midrst_mem", 64'(mem[2305]), 64'(ref_m[2305]));

    send(5, 0, 8'h77, 0);
    clear_start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ref_m[a] = 36'h080808080;
      e.addr = a;
      e.data = ref_m[a];
      e.due = -1;
      expq.push_back(e);
    end
    @(negedge clk);
    clear_start = 1'b0;
    chk("clr_busy_rise", 64'(clear_busy), 64'd1);
    g = 0;
    while (clear_busy && g < 300) begin
      chk("clr_in_ready", 64'(in_ready), 64'd0);
      chk("clr_rd_en", 64'(rd_en), 64'd0);
      @(negedge clk);
      g++;
    end
    chk("clr_done", 64'(clear_busy), 64'd0);
    chk("clr_ready_back", 64'(in_ready), 64'd1);
    chk("clr_release", 64'(cyc), 64'(wcyc[$] + 1));
    chk("clr_burst", 64'(wcyc[$] - wcyc[$-15]), 64'd15);
    drain();
    for (int a = 0; a < 16; a++)
      chk("clr_mem", 64'(mem[a]), 64'(ref_m[a]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
